// File: rtl/matrix_loader_if.sv
// matrix_loader_if: upstream word stream into matrix_loader (valid/ready handshake).
interface matrix_loader_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   modport master (output in_valid, in_data, input in_ready);
   modport slave (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/matrix_loader.sv
// matrix_loader: parses a dimension header, loads two row-major operand matrices, presents them to a multiplier.
// Define MATRIX_LOADER_ZERO_FILL_EN to clear both operand arrays on every accepted header.
module matrix_loader #(
   parameter int MAX_ELEMS = 4
) (
   input  logic                CLK,
   input  logic                RST_N,
   matrix_loader_if.slave      bus,
   output logic [31:0]         flat_matrix_1 [0:MAX_ELEMS-1],
   output logic [31:0]         flat_matrix_2 [0:MAX_ELEMS-1],
   output logic [3:0]          R1,
   output logic [3:0]          C1,
   output logic [3:0]          R2,
   output logic [3:0]          C2,
   output logic                readybit,
   input  logic                startbit,
   output logic                hdr_err
);
`ifdef MATRIX_LOADER_ZERO_FILL_EN
   localparam bit ZERO_FILL = 1'b1;
`else
   localparam bit ZERO_FILL = 1'b0;
`endif
   localparam logic [7:0] ME = 8'(MAX_ELEMS);
   typedef enum logic [1:0] {IDLE, LOAD1, LOAD2, PRESENT} state_t;
   state_t     state, state_n;
   logic [7:0] idx, n1, n2, h_n1, h_n2;
   logic [3:0] h_r1, h_c1, h_r2, h_c2;
   logic       beat, h_ok, hdr_load, last1, last2, unused_hi;
   assign bus.in_ready = RST_N && state != PRESENT;
   assign beat = bus.in_valid && bus.in_ready;
   assign {h_c2, h_r2, h_c1, h_r1} = bus.in_data[15:0];
   assign unused_hi = ^bus.in_data[31:16];
   // products at 8 bits so a 4x4 header cannot wrap past the size check
   assign h_n1 = {4'b0, h_r1} * {4'b0, h_c1};
   assign h_n2 = {4'b0, h_r2} * {4'b0, h_c2};
   assign n1 = {4'b0, R1} * {4'b0, C1};
   assign n2 = {4'b0, R2} * {4'b0, C2};
   assign h_ok = |h_r1 && |h_c1 && |h_r2 && |h_c2 && h_c1 == h_r2 && h_n1 <= ME && h_n2 <= ME;
   assign last1 = idx == n1 - 8'd1;
   assign last2 = idx == n2 - 8'd1;
   assign readybit = state == PRESENT;
   always_comb begin
      state_n = state;
      hdr_load = 1'b0;
      unique case (state)
         IDLE: begin
            hdr_load = beat && h_ok;
            state_n = hdr_load ? LOAD1 : IDLE;
         end
         LOAD1:   state_n = beat && last1 ? LOAD2 : LOAD1;
         LOAD2:   state_n = beat && last2 ? PRESENT : LOAD2;
         PRESENT: state_n = startbit ? IDLE : PRESENT;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!RST_N) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         idx <= 8'd0;
         hdr_err <= 1'b0;
         {R1, C1, R2, C2} <= 16'd0;
         for (int i = 0; i < MAX_ELEMS; i++) begin
            flat_matrix_1[i] <= 32'd0;
            flat_matrix_2[i] <= 32'd0;
         end
      end else begin
         hdr_err <= beat && state == IDLE && !h_ok;
         if (hdr_load) begin
            {R1, C1, R2, C2} <= {h_r1, h_c1, h_r2, h_c2};
            idx <= 8'd0;
         end else if (beat && (state == LOAD1 || state == LOAD2))
            idx <= (state == LOAD1 ? last1 : last2) ? 8'd0 : idx + 8'd1;
         for (int i = 0; i < MAX_ELEMS; i++) begin
            if (hdr_load && ZERO_FILL) begin
               flat_matrix_1[i] <= 32'd0;
               flat_matrix_2[i] <= 32'd0;
            end
            if (beat && state == LOAD1 && idx == 8'(i)) flat_matrix_1[i] <= bus.in_data;
            if (beat && state == LOAD2 && idx == 8'(i)) flat_matrix_2[i] <= bus.in_data;
         end
      end
   end
endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: header table, directed corner sequences and random transactions against an array model.
module tb_matrix_loader;
   localparam int ME = 4;
   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        startbit = 1'b0;
   logic [31:0] fm1 [0:ME-1];
   logic [31:0] fm2 [0:ME-1];
   logic [3:0]  R1, C1, R2, C2;
   logic        readybit, hdr_err;
   matrix_loader_if bus();
   matrix_loader #(.MAX_ELEMS(ME)) dut (
      .CLK(CLK), .RST_N(RST_N), .bus(bus), .flat_matrix_1(fm1), .flat_matrix_2(fm2),
      .R1(R1), .C1(C1), .R2(R2), .C2(C2), .readybit(readybit), .startbit(startbit), .hdr_err(hdr_err)
   );
   always #5 CLK = ~CLK;
   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1);
   end
   typedef struct { logic [31:0] h; logic err; } vec_t;
   vec_t        tbl [12];
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] em1 [0:ME-1];
   logic [31:0] em2 [0:ME-1];
   logic [3:0]  er1, ec1, er2, ec2;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic model_clear();
      for (int i = 0; i < ME; i++) begin
         em1[i] = 0;
         em2[i] = 0;
      end
   endtask
   task automatic chk_out(input string nm, input logic rdy, input logic irdy);
      chk({nm, ":readybit"}, {31'b0, readybit}, {31'b0, rdy});
      chk({nm, ":in_ready"}, {31'b0, bus.in_ready}, {31'b0, irdy});
      chk({nm, ":dims"}, {16'b0, R1, C1, R2, C2}, {16'b0, er1, ec1, er2, ec2});
      for (int i = 0; i < ME; i++) begin
         chk($sformatf("%s:m1[%0d]", nm, i), fm1[i], em1[i]);
         chk($sformatf("%s:m2[%0d]", nm, i), fm2[i], em2[i]);
      end
   endtask
   function automatic logic hdr_ok(input logic [31:0] h);
      int r1 = int'(h[3:0]), c1 = int'(h[7:4]), r2 = int'(h[11:8]), c2 = int'(h[15:12]);
      return r1 > 0 && c1 > 0 && r2 > 0 && c2 > 0 && c1 == r2 && r1 * c1 <= ME && r2 * c2 <= ME;
   endfunction
   task automatic send(input logic [31:0] d, input int gmax);
      int g = gmax > 0 ? int'($urandom_range(gmax, 0)) : 0;
      repeat (g) begin
         bus.in_valid = 1'b0;
         bus.in_data = $urandom;
         tick();
      end
      chk("in_ready_before_beat", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data = d;
      tick();
      bus.in_valid = 1'b0;
   endtask
   task automatic header(input logic [31:0] h, input logic exp_err);
      logic ok = hdr_ok(h);
      send(h, 2);
      chk($sformatf("hdr_err[%0h]", h), {31'b0, hdr_err}, {31'b0, exp_err});
      if (ok) begin
         {ec2, er2, ec1, er1} = h[15:0];
`ifdef MATRIX_LOADER_ZERO_FILL_EN
         model_clear();
`endif
      end
      chk_out("after_hdr", 1'b0, 1'b1);
      if (!ok) begin
         tick();
         chk("hdr_err_pulse_end", {31'b0, hdr_err}, 32'd0);
      end
   endtask
   task automatic load(input logic rnd, input logic [31:0] base, input int gmax);
      int n1 = int'(er1) * int'(ec1), n2 = int'(er2) * int'(ec2);
      logic [31:0] d;
      for (int k = 0; k < n1 + n2; k++) begin
         d = rnd ? $urandom : base + 32'(k);
         send(d, gmax);
         if (k < n1) em1[k] = d;
         else em2[k - n1] = d;
         if (k < n1 + n2 - 1) chk("readybit_during_load", {31'b0, readybit}, 32'd0);
      end
      chk_out("loaded", 1'b1, 1'b0);
   endtask
   task automatic present(input int hold);
      repeat (hold) begin
         bus.in_valid = 1'b1;
         bus.in_data = 32'hDEAD;
         tick();
         chk_out("hold", 1'b1, 1'b0);
      end
      bus.in_valid = 1'b0;
      startbit = 1'b1;
      tick();
      startbit = 1'b0;
      chk_out("released", 1'b0, 1'b1);
   endtask
   initial begin
      logic [31:0] h;
      logic [3:0] a, b, c;
      tbl[0]  = '{32'h0000_2222, 1'b0};
      tbl[1]  = '{32'h0000_2232, 1'b1};
      tbl[2]  = '{32'h0000_0222, 1'b1};
      tbl[3]  = '{32'h0000_3333, 1'b1};
      tbl[4]  = '{32'h0000_1221, 1'b0};
      tbl[5]  = '{32'h0000_1111, 1'b0};
      tbl[6]  = '{32'h0000_4114, 1'b0};
      tbl[7]  = '{32'h0000_1441, 1'b0};
      tbl[8]  = '{32'h0000_0000, 1'b1};
      tbl[9]  = '{32'hFFFF_2222, 1'b0};
      tbl[10] = '{32'h0000_2212, 1'b1};
      tbl[11] = '{32'h0000_5115, 1'b1};
      bus.in_valid = 1'b0;
      bus.in_data = 32'd0;
      model_clear();
      {er1, ec1, er2, ec2} = 16'd0;
      repeat (3) tick();
      chk_out("in_reset", 1'b0, 1'b0);
      chk("reset_hdr_err", {31'b0, hdr_err}, 32'd0);
      RST_N = 1'b1;
      #1;
      chk_out("reset_release", 1'b0, 1'b1);
      startbit = 1'b1;
      tick();
      startbit = 1'b0;
      chk_out("idle_startbit_ignored", 1'b0, 1'b1);
      header(32'h2222, 1'b0);
      load(1'b0, 32'd1, 0);
      chk("direct_m1_3", fm1[3], 32'd4);
      chk("direct_m2_0", fm2[0], 32'd5);
      present(5);
      header(32'h2232, 1'b1);
      header(32'h0222, 1'b1);
      header(32'h3333, 1'b1);
      header(32'h1221, 1'b0);
      load(1'b0, 32'd9, 3);
      chk("direct_m1_1", fm1[1], 32'd10);
      chk("direct_m2_1", fm2[1], 32'd12);
`ifdef MATRIX_LOADER_ZERO_FILL_EN
      chk("direct_m1_2_zero", fm1[2], 32'd0);
`else
      chk("direct_m1_2_prior", fm1[2], 32'd3);
`endif
      present(2);
      header(32'h2222, 1'b0);
      send(32'hA1, 1);
      send(32'hA2, 1);
      RST_N = 1'b0;
      tick();
      model_clear();
      {er1, ec1, er2, ec2} = 16'd0;
      chk_out("reset_abort", 1'b0, 1'b0);
      RST_N = 1'b1;
      #1;
      chk_out("after_abort", 1'b0, 1'b1);
      header(32'h2222, 1'b0);
      load(1'b1, 32'd0, 1);
      present(1);
      for (int i = 0; i < 12; i++) begin
         header(tbl[i].h, tbl[i].err);
         if (!tbl[i].err) begin
            load(1'b1, 32'd0, 2);
            present(int'($urandom_range(3, 0)));
         end
      end
      repeat (40) begin
         a = 4'($urandom_range(4, 1));
         b = 4'($urandom_range(4, 1));
         c = 4'($urandom_range(4, 1));
         h = $urandom_range(3, 0) == 0 ? $urandom : {$urandom_range(65535, 0), c, b, b, a};
         header(h, !hdr_ok(h));
         if (hdr_ok(h)) begin
            load(1'b1, 32'd0, 2);
            present(int'($urandom_range(2, 0)));
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
